// File: rtl/reg_file.sv
// reg_file: 32 x XLEN integer register file for the RISC-V pipeline.
// Two combinational read ports (decode) and one synchronous write port
// (write-back). x0 reads as zero; optional write-first bypass on reads.
module reg_file #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic [XLEN-1:0]         wd,
  input  logic [$clog2(NREG)-1:0] ra1,
  input  logic [$clog2(NREG)-1:0] ra2,
  output logic [XLEN-1:0]         rd1,
  output logic [XLEN-1:0]         rd2
);

  localparam int AW = $clog2(NREG);

  // Entry 0 is cleared on reset and never written, so it is a constant
  // zero that synthesis removes; keeping it lets reads index uniformly.
  logic [XLEN-1:0] regs [NREG];

  logic fwd1;
  logic fwd2;

  // Storage: async clear of every register, then one write per edge
  // with writes to x0 discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Forwarding is independent of reset so write-back data reaches decode
  // in the same cycle it is presented, even while storage is held clear.
  always_comb begin
    fwd1 = (BYPASS != 0) && we && (wa == ra1);
    fwd2 = (BYPASS != 0) && we && (wa == ra2);
  end

  // Read ports in priority order: x0, forwarded write data, storage.
  always_comb begin
    if (ra1 == AW'(0)) begin
      rd1 = '0;
    end else if (fwd1) begin
      rd1 = wd;
    end else begin
      rd1 = regs[ra1];
    end
    if (ra2 == AW'(0)) begin
      rd2 = '0;
    end else if (fwd2) begin
      rd2 = wd;
    end else begin
      rd2 = regs[ra2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file. Two instances
// share all inputs: dut (forwarding on) and dut_nb (forwarding off).
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] rd1_nb;
  logic [31:0] rd2_nb;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
  );

  reg_file #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive all inputs at the falling edge, then let combinational reads settle.
  task automatic applyStimulus(input logic w, input logic [4:0] a,
                               input logic [31:0] d, input logic [4:0] r1,
                               input logic [4:0] r2);
    @(negedge clk);
    we  = w;
    wa  = a;
    wd  = d;
    ra1 = r1;
    ra2 = r2;
    #1;
  endtask

  // Advance past the next rising edge and sample away from it.
  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    $display("[TB] start");

    // Reads during reset return 0; forwarding still applies on dut.
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
    checkOutput("reset_rd1_x5", rd1, 32'd0);
    checkOutput("reset_rd2_x31", rd2, 32'd0);
    applyStimulus(1'b1, 5'd4, 32'h44, 5'd4, 5'd4);
    checkOutput("reset_fwd_byp", rd1, 32'h44);
    checkOutput("reset_fwd_nobyp", rd1_nb, 32'd0);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd4, 5'd4);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_write_ignored", rd1, 32'd0);
    checkOutput("reset_write_ignored_nb", rd2_nb, 32'd0);

    // Back-to-back writes to x5 and x10.
    applyStimulus(1'b1, 5'd5, 32'd99, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b1, 5'd10, 32'd12345, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd10);
    checkOutput("x5_rd1", rd1, 32'd99);
    checkOutput("x10_rd2", rd2, 32'd12345);
    checkOutput("x5_rd1_nb", rd1_nb, 32'd99);
    checkOutput("x10_rd2_nb", rd2_nb, 32'd12345);

    // x0 stays zero, including while a write to x0 is presented.
    applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
    checkOutput("x0_during_write", rd1, 32'd0);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    checkOutput("x0_rd1", rd1, 32'd0);
    checkOutput("x0_rd2", rd2, 32'd0);
    checkOutput("x0_rd1_nb", rd1_nb, 32'd0);

    // we=0 across several edges leaves x5 untouched.
    applyStimulus(1'b0, 5'd5, 32'd55, 5'd5, 5'd5);
    clockEdge();
    clockEdge();
    clockEdge();
    checkOutput("we0_hold_x5", rd1, 32'd99);
    checkOutput("we0_hold_x5_nb", rd2_nb, 32'd99);

    // Read-during-write to x6: forwarded vs. old value before the edge.
    applyStimulus(1'b1, 5'd6, 32'd1, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b1, 5'd6, 32'd2, 5'd6, 5'd6);
    checkOutput("rdw_before_byp", rd1, 32'd2);
    checkOutput("rdw_before_nobyp", rd1_nb, 32'd1);
    clockEdge();
    checkOutput("rdw_after_byp", rd1, 32'd2);
    checkOutput("rdw_after_nobyp", rd1_nb, 32'd2);

    // All-ones in x31 seen on both ports.
    applyStimulus(1'b1, 5'd31, 32'hFFFFFFFF, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
    checkOutput("x31_rd1", rd1, 32'hFFFFFFFF);
    checkOutput("x31_rd2", rd2, 32'hFFFFFFFF);

    // Write every register with its own index, then read them all back.
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
      clockEdge();
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
      checkOutput($sformatf("idx_rd1_x%0d", i), rd1, 32'(i));
      checkOutput($sformatf("idx_rd2_x%0d", 31 - i), rd2, 32'(31 - i));
      checkOutput($sformatf("idx_nb_x%0d", i), rd1_nb, 32'(i));
    end

    // Asynchronous reset mid-cycle clears x3 without a clock edge.
    applyStimulus(1'b1, 5'd3, 32'd7, 5'd3, 5'd0);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd5);
    checkOutput("x3_written", rd1, 32'd7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_x3", rd1, 32'd0);
    checkOutput("async_reset_x5", rd2_nb, 32'd0);
    applyStimulus(1'b1, 5'd3, 32'd9, 5'd5, 5'd3);
    checkOutput("reset_fwd_x3_byp", rd2, 32'd9);
    checkOutput("reset_fwd_x3_nobyp", rd2_nb, 32'd0);
    clockEdge();
    checkOutput("reset_x5_after_edge", rd1, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd31);
    rst_n = 1'b1;
    #1;
    checkOutput("x3_after_reset", rd1, 32'd0);
    checkOutput("x31_after_reset", rd2, 32'd0);
    checkOutput("x3_after_reset_nb", rd1_nb, 32'd0);

    // First write after deassertion is accepted.
    applyStimulus(1'b1, 5'd3, 32'd21, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    checkOutput("first_write_after_reset", rd1, 32'd21);
    checkOutput("first_write_after_reset_nb", rd2_nb, 32'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
